// File: rtl/ddr2_sdram_phy_alt_mem_phy_pll_phs_shft_ctrl_if.sv
// Sequencer- and PLL-facing signals of the PLL phase-shift controller.
// The controller connects through the slave modport.
interface ddr2_sdram_phy_alt_mem_phy_pll_phs_shft_ctrl_if #(
   parameter int CLOCK_INDEX_WIDTH = 3
);
   logic                         seq_pll_start_reconfig;
   logic [CLOCK_INDEX_WIDTH-1:0] seq_pll_select;
   logic                         seq_pll_inc_dec_n;
   logic                         pll_phasedone;
   logic [CLOCK_INDEX_WIDTH-1:0] pll_phasecounterselect;
   logic                         pll_phaseupdown;
   logic                         pll_phasestep;
   logic                         phs_shft_busy;
   logic                         phs_shft_done;
   logic                         phs_shft_timeout_err;
   logic                         phs_shft_overrun_err;
   logic [15:0]                  phs_shft_step_count;

   modport master (
      output seq_pll_start_reconfig, seq_pll_select, seq_pll_inc_dec_n, pll_phasedone,
      input  pll_phasecounterselect, pll_phaseupdown, pll_phasestep, phs_shft_busy,
             phs_shft_done, phs_shft_timeout_err, phs_shft_overrun_err, phs_shft_step_count
   );

   modport slave (
      input  seq_pll_start_reconfig, seq_pll_select, seq_pll_inc_dec_n, pll_phasedone,
      output pll_phasecounterselect, pll_phaseupdown, pll_phasestep, phs_shft_busy,
             phs_shft_done, phs_shft_timeout_err, phs_shft_overrun_err, phs_shft_step_count
   );
endinterface

// File: rtl/ddr2_sdram_phy_alt_mem_phy_pll_phs_shft_ctrl.sv
// PLL dynamic phase-shift controller: one phasestep per sequencer request edge,
// then waits for the PLL phasedone low/high handshake with a per-edge timeout.
module ddr2_sdram_phy_alt_mem_phy_pll_phs_shft_ctrl #(
   parameter int CLOCK_INDEX_WIDTH             = 3,
   parameter int PHASESTEP_CYCLES              = 2,
   parameter int TIMEOUT_CYCLES                = 255,
   parameter int METASTABILITY_GUARD_REGISTERS = 2
) (
   input  logic seq_clk,
   input  logic reset_seq_n,
   ddr2_sdram_phy_alt_mem_phy_pll_phs_shft_ctrl_if.slave bus
);
   localparam int CNT_MAX = (TIMEOUT_CYCLES > PHASESTEP_CYCLES) ? TIMEOUT_CYCLES : PHASESTEP_CYCLES;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
   localparam int G       = METASTABILITY_GUARD_REGISTERS;

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_SETUP, S_STEP, S_WAIT_LOW, S_WAIT_HIGH, S_DONE
   } state_t;

   state_t                       state_q, state_d;
   logic [G-1:0]                 pd_sync_q;
   logic                         pd_s;
   logic                         req_prev_q;
   logic                         req;
   logic [CNT_W-1:0]             cnt_q, cnt_d, cnt_inc;
   logic [CLOCK_INDEX_WIDTH-1:0] sel_q, sel_d;
   logic                         updown_q, updown_d;
   logic                         timed_out_q, timed_out_d;
   logic                         to_err_q, to_err_d;
   logic                         ovr_err_q, ovr_err_d;
   logic [15:0]                  count_q, count_d;

   assign pd_s    = pd_sync_q[G-1];
   assign req     = bus.seq_pll_start_reconfig & ~req_prev_q;
   assign cnt_inc = cnt_q + 1'b1;

   always_ff @(posedge seq_clk) begin
      if (!reset_seq_n) begin
         pd_sync_q <= '0;
      end else begin
         pd_sync_q[0] <= bus.pll_phasedone;
         for (int unsigned i = 1; i < G; i++) pd_sync_q[i] <= pd_sync_q[i-1];
      end
   end

   always_ff @(posedge seq_clk) begin
      if (!reset_seq_n) begin
         state_q     <= S_INIT;
         req_prev_q  <= 1'b1;
         cnt_q       <= '0;
         sel_q       <= '0;
         updown_q    <= 1'b0;
         timed_out_q <= 1'b0;
         to_err_q    <= 1'b0;
         ovr_err_q   <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         req_prev_q  <= bus.seq_pll_start_reconfig;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         updown_q    <= updown_d;
         timed_out_q <= timed_out_d;
         to_err_q    <= to_err_d;
         ovr_err_q   <= ovr_err_d;
         count_q     <= count_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = '0;
      sel_d       = sel_q;
      updown_d    = updown_q;
      timed_out_d = timed_out_q;
      to_err_d    = to_err_q;
      count_d     = count_q;
      // Any edge outside IDLE (including DONE's last cycle) is dropped as an overrun.
      ovr_err_d   = ovr_err_q | (req & (state_q != S_IDLE));
      case (state_q)
         S_INIT:  if (pd_s) state_d = S_IDLE;
         S_IDLE: begin
            if (req) begin
               sel_d       = bus.seq_pll_select;
               updown_d    = bus.seq_pll_inc_dec_n;
               timed_out_d = 1'b0;
               state_d     = S_SETUP;
            end
         end
         S_SETUP: state_d = S_STEP;
         S_STEP: begin
            if (cnt_q == CNT_W'(PHASESTEP_CYCLES - 1)) state_d = S_WAIT_LOW;
            else                                       cnt_d   = cnt_inc;
         end
         S_WAIT_LOW: begin
            if (!pd_s) begin
               state_d = S_WAIT_HIGH;
            end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
               state_d     = S_DONE;
               to_err_d    = 1'b1;
               timed_out_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_WAIT_HIGH: begin
            if (pd_s) begin
               state_d = S_DONE;
            end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
               state_d     = S_DONE;
               to_err_d    = 1'b1;
               timed_out_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (!timed_out_q && (count_q != '1)) count_d = count_q + 16'd1;
         end
         default: state_d = S_INIT;
      endcase
   end

   assign bus.pll_phasecounterselect = sel_q;
   assign bus.pll_phaseupdown        = updown_q;
   assign bus.pll_phasestep          = (state_q == S_STEP);
   assign bus.phs_shft_busy          = (state_q != S_IDLE);
   assign bus.phs_shft_done          = (state_q == S_DONE);
   assign bus.phs_shft_timeout_err   = to_err_q;
   assign bus.phs_shft_overrun_err   = ovr_err_q;
   assign bus.phs_shft_step_count    = count_q;
endmodule

// File: tb/tb_ddr2_sdram_phy_alt_mem_phy_pll_phs_shft_ctrl.sv
// Randomized bench for the PLL phase-shift controller; expected timing of each
// step is derived arithmetically from request time and PLL phasedone behaviour.
module tb_ddr2_sdram_phy_alt_mem_phy_pll_phs_shft_ctrl;
   localparam int CIW = 3;
   localparam int PSC = 2;
   localparam int TMO = 255;
   localparam int MGR = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ddr2_sdram_phy_alt_mem_phy_pll_phs_shft_ctrl_if #(.CLOCK_INDEX_WIDTH(CIW)) bus ();

   ddr2_sdram_phy_alt_mem_phy_pll_phs_shft_ctrl #(
      .CLOCK_INDEX_WIDTH(CIW),
      .PHASESTEP_CYCLES(PSC),
      .TIMEOUT_CYCLES(TMO),
      .METASTABILITY_GUARD_REGISTERS(MGR)
   ) u_dut (
      .seq_clk(clk),
      .reset_seq_n(rst_n),
      .bus(bus)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned exp_count;
   bit          exp_to, exp_ovr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_flags(input string tag);
      chk({tag, "_count"}, 32'(bus.phs_shft_step_count), exp_count);
      chk({tag, "_toerr"}, 32'(bus.phs_shft_timeout_err), 32'(exp_to));
      chk({tag, "_ovrerr"}, 32'(bus.phs_shft_overrun_err), 32'(exp_ovr));
   endtask

   // Releases reset and checks busy stays high for release cycle + 2 sync cycles.
   task automatic release_reset();
      int unsigned busy_n;
      busy_n = 0;
      tick();
      rst_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         if (n > 0) tick();
         @(negedge clk);
         if (bus.phs_shft_busy) busy_n++;
      end
      chk("init_busy_cycles", busy_n, 3);
   endtask

   task automatic do_reset(input bit hold_req);
      rst_n = 1'b0;
      bus.pll_phasedone          = 1'b1;
      bus.seq_pll_start_reconfig = hold_req;
      bus.seq_pll_select         = '0;
      bus.seq_pll_inc_dec_n      = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      exp_count = 0; exp_to = 1'b0; exp_ovr = 1'b0;
      chk("rst_busy", 32'(bus.phs_shft_busy), 1);
      chk("rst_step", 32'(bus.pll_phasestep), 0);
      chk("rst_sel", 32'(bus.pll_phasecounterselect), 0);
      chk("rst_updown", 32'(bus.pll_phaseupdown), 0);
      chk("rst_done", 32'(bus.phs_shft_done), 0);
      chk_flags("rst");
      release_reset();
   endtask

   // mode 0: normal handshake, 1: phasedone never drops, 2: phasedone never returns.
   task automatic do_step(input int sel, input bit dir, input int d, input int len,
                          input int mode, input int ovr_at);
      int done_exp, rise_n, width, done_cnt, done_n, busy_lo, sel_bad;
      bit low;
      case (mode)
         0:       done_exp = 5 + d + len;
         1:       done_exp = 4 + TMO;
         default: done_exp = 5 + d + TMO;
      endcase
      rise_n = -1; width = 0; done_cnt = 0; done_n = -1; busy_lo = 0; sel_bad = 0;
      tick();
      bus.seq_pll_select         = CIW'(sel);
      bus.seq_pll_inc_dec_n      = dir;
      bus.seq_pll_start_reconfig = 1'b1;
      for (int n = 1; n <= done_exp + 1; n++) begin
         tick();
         if (n == 1) bus.seq_pll_start_reconfig = 1'b0;
         bus.seq_pll_select    = CIW'($urandom);
         bus.seq_pll_inc_dec_n = 1'($urandom);
         if (ovr_at != 0 && n == ovr_at)     bus.seq_pll_start_reconfig = 1'b1;
         if (ovr_at != 0 && n == ovr_at + 1) bus.seq_pll_start_reconfig = 1'b0;
         low = (mode != 1) && (n >= 2 + d) && (mode == 2 || n < 2 + d + len);
         bus.pll_phasedone = ~low;
         @(negedge clk);
         if (bus.pll_phasestep) begin
            width++;
            if (rise_n < 0) begin
               rise_n = n;
               chk("sel_at_rise", 32'(bus.pll_phasecounterselect), 32'(sel));
               chk("dir_at_rise", 32'(bus.pll_phaseupdown), 32'(dir));
            end
         end
         if (bus.phs_shft_done) begin
            done_cnt++;
            done_n = n;
         end
         if (n <= done_exp && !bus.phs_shft_busy) busy_lo++;
         if (bus.pll_phasecounterselect != CIW'(sel) || bus.pll_phaseupdown != dir) sel_bad++;
      end
      bus.pll_phasedone = 1'b1;
      if (mode == 0) exp_count++;
      else           exp_to = 1'b1;
      if (ovr_at != 0) exp_ovr = 1'b1;
      chk("step_latency", 32'(rise_n), 2);
      chk("step_width", 32'(width), PSC);
      chk("done_pulses", 32'(done_cnt), 1);
      chk("done_cycle", 32'(done_n), 32'(done_exp));
      chk("busy_low_early", 32'(busy_lo), 0);
      chk("sel_dir_stable", 32'(sel_bad), 0);
      chk("busy_after_done", 32'(bus.phs_shft_busy), 0);
      chk_flags("step");
   endtask

   task automatic held_req_check();
      int steps;
      steps = 0;
      for (int n = 0; n < 8; n++) begin
         tick();
         @(negedge clk);
         if (bus.pll_phasestep) steps++;
      end
      chk("held_req_nostep", 32'(steps), 0);
      chk("held_req_ovr", 32'(bus.phs_shft_overrun_err), 0);
      bus.seq_pll_start_reconfig = 1'b0;
      tick();
   endtask

   task automatic midstep_reset();
      int dones;
      dones = 0;
      tick();
      bus.seq_pll_select         = 3'd6;
      bus.seq_pll_inc_dec_n      = 1'b1;
      bus.seq_pll_start_reconfig = 1'b1;
      tick();
      bus.seq_pll_start_reconfig = 1'b0;
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_step_before", 32'(bus.pll_phasestep), 1);
      tick();
      @(negedge clk);
      chk("midrst_step_after", 32'(bus.pll_phasestep), 0);
      exp_count = 0; exp_to = 1'b0; exp_ovr = 1'b0;
      chk_flags("midrst");
      for (int n = 0; n < 4; n++) begin
         tick();
         @(negedge clk);
         if (bus.phs_shft_done) dones++;
      end
      chk("midrst_no_done", 32'(dones), 0);
      release_reset();
   endtask

   initial begin
      int d, len, mode, ovr;
      do_reset(1'b0);
      do_step(2, 1'b1, 3, 4, 0, 0);
      do_step(5, 1'b0, 1, 2, 1, 0);
      do_step(7, 1'b0, 0, 1, 0, 0);
      do_step(4, 1'b1, 3, 6, 0, 10);
      do_step(1, 1'b0, 2, 3, 0, 10);
      do_step(3, 1'b1, 2, 5, 2, 0);
      for (int i = 0; i < 16; i++) begin
         d    = int'($urandom_range(0, 6));
         len  = int'($urandom_range(1, 8));
         mode = ($urandom_range(0, 9) == 0) ? 2 : 0;
         ovr  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 5 + d + len)) : 0;
         do_step(int'($urandom_range(0, 7)), 1'($urandom), d, len, mode, ovr);
      end
      do_reset(1'b1);
      held_req_check();
      do_step(6, 1'b1, 2, 2, 0, 0);
      midstep_reset();
      do_step(0, 1'b0, 1, 3, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
